alu_muldiv_seq: RTL and testbench

// - Iterative HI/LO multiply/divide unit for the MIPS-subset datapath; it is the initiator on the 3-bit-command ALU port.
// - Runs shift-add multiply (one ADD per cycle) and restoring divide (one SUB per cycle) on an external ALU instance.
// - Takes jobs over a valid/ready start handshake and returns HI/LO over a valid/ready done handshake.

---
 rtl/alu_muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative HI/LO multiply/divide sequencer driving an external ALU (ADD/SUB).
// Define SIGNED_MULDIV_EN to make MULT/DIV (op[0]=1) signed via a one-cycle FIX state.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [2:0]       alu_command,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic             is_div_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;   // product high half / remainder
    logic [WIDTH-1:0] mpr_reg, mpr_next;   // multiplier-low half / quotient
    logic [WIDTH-1:0] opb_reg;             // multiplicand or divisor
    logic             dbz_reg;
    logic             accept;
    logic             last_step;
    logic             fix_needed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] div_s;
    logic             div_ge;

    assign accept    = start_valid && (state_reg == IDLE);
    assign last_step = (count_reg == CW'(WIDTH - 1));

`ifdef SIGNED_MULDIV_EN
    logic               neg_a, neg_b;
    logic               neg_a_reg, neg_b_reg, signed_reg;
    logic [2*WIDTH-1:0] prod_neg;

    assign neg_a      = op[0] & src_a[WIDTH-1];
    assign neg_b      = op[0] & src_b[WIDTH-1];
    assign mag_a      = neg_a ? -src_a : src_a;
    assign mag_b      = neg_b ? -src_b : src_b;
    assign fix_needed = signed_reg;
    assign prod_neg   = -{acc_reg, mpr_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            signed_reg <= 1'b0;
        end else if (accept) begin
            neg_a_reg  <= neg_a;
            neg_b_reg  <= neg_b;
            signed_reg <= op[0];
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign mag_a      = src_a;
    assign mag_b      = src_b;
    assign fix_needed = 1'b0;
`endif

    // Restoring-divide trial: shift next dividend bit into the partial remainder.
    assign div_s  = {acc_reg[WIDTH-2:0], mpr_reg[WIDTH-1]};
    assign div_ge = acc_reg[WIDTH-1] | (div_s >= opb_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last_step) state_next = fix_needed ? FIX : DONE;
            FIX:     state_next = DONE;
            DONE:    if (done_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc_reg;
        mpr_next = mpr_reg;
        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    acc_next = '0;
                    mpr_next = op[1] ? mag_a : mag_b;
                end
            end
            RUN: begin
                if (is_div_reg) begin
                    acc_next = div_ge ? alu_result : div_s;
                    mpr_next = {mpr_reg[WIDTH-2:0], div_ge};
                end else begin
                    acc_next = {alu_carryout, alu_result[WIDTH-1:1]};
                    mpr_next = {alu_result[0], mpr_reg[WIDTH-1:1]};
                end
            end
`ifdef SIGNED_MULDIV_EN
            FIX: begin
                // Remainder follows the dividend sign; quotient/product follow sign parity.
                if (is_div_reg) begin
                    acc_next = neg_a_reg ? -acc_reg : acc_reg;
                    mpr_next = (neg_a_reg ^ neg_b_reg) ? -mpr_reg : mpr_reg;
                end else if (neg_a_reg ^ neg_b_reg) begin
                    acc_next = prod_neg[2*WIDTH-1:WIDTH];
                    mpr_next = prod_neg[WIDTH-1:0];
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            acc_reg    <= '0;
            mpr_reg    <= '0;
            opb_reg    <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            mpr_reg <= mpr_next;
            if (accept) begin
                count_reg  <= '0;
                is_div_reg <= op[1];
                opb_reg    <= op[1] ? mag_b : mag_a;
                dbz_reg    <= op[1] && (src_b == '0);
            end else if (state_reg == RUN) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        start_ready = (state_reg == IDLE);
        done_valid  = (state_reg == DONE);
        alu_command = 3'b000;
        alu_a       = '0;
        alu_b       = '0;
        if (state_reg == RUN) begin
            if (is_div_reg) begin
                alu_command = 3'b001;
                alu_a       = div_s;
                alu_b       = opb_reg;
            end else begin
                alu_command = 3'b000;
                alu_a       = acc_reg;
                alu_b       = mpr_reg[0] ? opb_reg : '0;
            end
        end
    end

    assign hi          = acc_reg;
    assign lo          = mpr_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: vector table, random jobs vs. arithmetic model,
// and hand-written stall / reset-mid-run sequences. Contains a behavioural ADD/SUB ALU.
module tb_alu_muldiv_seq;
    localparam int W = 32;
`ifdef SIGNED_MULDIV_EN
    localparam bit SGN = 1'b1;
    localparam int SLAT = 33;
`else
    localparam bit SGN = 1'b0;
    localparam int SLAT = 32;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic [2:0]    alu_command;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          alu_carryout;
    logic          done_valid;
    logic          done_ready;
    logic [W-1:0]  hi, lo;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .src_a(src_a), .src_b(src_b),
        .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .done_valid(done_valid), .done_ready(done_ready),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    // External ALU: ADD with carry, SUB
    always_comb begin
        alu_result   = '0;
        alu_carryout = 1'b0;
        case (alu_command)
            3'b000: {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: begin
                alu_result   = alu_a - alu_b;
                alu_carryout = (alu_a >= alu_b);
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Plain-arithmetic reference for HI/LO results
    function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] up;
        bit sg;
        sg = SGN && o[0];
        z  = o[1] && (b == 0);
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!o[1]) begin
            if (sg) begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end else begin
                up = {32'b0, a} * {32'b0, b};
                h = up[63:32];
                l = up[31:0];
            end
        end else if (b == 0) begin
            l = '1;
            h = a;
        end else if (sg) begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
        return (SGN && o[0]) ? 33 : 32;
    endfunction

    task automatic wait_done(input logic [1:0] o, output int lat, output int badcmd);
        lat = 0;
        badcmd = 0;
        while (done_valid !== 1'b1 && lat < 100) begin
            if (lat < 32 && alu_command !== (o[1] ? 3'b001 : 3'b000)) badcmd++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Starts from IDLE, #1 after a posedge; returns sampled results, then handshakes.
    task automatic run_job(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] h, output logic [W-1:0] l, output logic z,
                           output int lat, output int badcmd);
        op = o; src_a = a; src_b = b; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        wait_done(o, lat, badcmd);
        h = hi; l = lo; z = div_by_zero;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
    endtask

    task automatic job_and_check(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                                 input logic ez, input int elat);
        logic [W-1:0] h, l;
        logic z;
        int lat, badcmd;
        run_job(o, a, b, h, l, z, lat, badcmd);
        chk({tag, " hi"}, 64'(h), 64'(eh));
        chk({tag, " lo"}, 64'(l), 64'(el));
        chk({tag, " dbz"}, 64'(z), 64'(ez));
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " alu_cmd"}, 64'(badcmd), 64'd0);
        chk({tag, " idle_after"}, 64'(start_ready), 64'd1);
        $display("job %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d", tag, o, a, b, h, l, z, lat);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " start_ready"}, 64'(start_ready), 64'd1);
        chk({tag, " done_valid"}, 64'(done_valid), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'd0);
        chk({tag, " lo"}, 64'(lo), 64'd0);
        chk({tag, " dbz"}, 64'(div_by_zero), 64'd0);
        chk({tag, " alu_command"}, 64'(alu_command), 64'd0);
        chk({tag, " alu_a"}, 64'(alu_a), 64'd0);
        chk({tag, " alu_b"}, 64'(alu_b), 64'd0);
    endtask

    initial begin
        vec_t tbl[$];
        logic [W-1:0] eh, el, ph, pl;
        logic ez, pz;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        int lat, badcmd;

        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl.push_back(vec_t'{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32});
        tbl.push_back(vec_t'{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32});
        tbl.push_back(vec_t'{2'b10, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 32});
        tbl.push_back(vec_t'{2'b00, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32});
        tbl.push_back(vec_t'{2'b10, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 32});
        tbl.push_back(vec_t'{2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 32});
        tbl.push_back(vec_t'{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 32});
`ifdef SIGNED_MULDIV_EN
        tbl.push_back(vec_t'{2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33});
        tbl.push_back(vec_t'{2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33});
        tbl.push_back(vec_t'{2'b01, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33});
        tbl.push_back(vec_t'{2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33});
`else
        tbl.push_back(vec_t'{2'b01, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0, 32});
        tbl.push_back(vec_t'{2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0, 32});
        tbl.push_back(vec_t'{2'b01, 32'd7, 32'hFFFFFFFA, 32'd6, 32'hFFFFFFD6, 1'b0, 32});
        tbl.push_back(vec_t'{2'b11, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0, 32});
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            job_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                          tbl[i].hi, tbl[i].lo, tbl[i].dbz, tbl[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (SGN && ro == 2'b11 && rb == 0) rb = 32'd1;
            ref_model(ro, ra, rb, eh, el, ez);
            job_and_check($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ez, exp_lat(ro));
        end

        // Stall in DONE with a stray start pulse, then handshake with start held high.
        ref_model(2'b00, 32'h1234, 32'h5678, ph, pl, pz);
        op = 2'b00; src_a = 32'h1234; src_b = 32'h5678; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        wait_done(2'b00, lat, badcmd);
        chk("stall latency", 64'(lat), 64'd32);
        for (int c = 0; c < 10; c++) begin
            start_valid = (c == 4);
            op = 2'b10; src_a = 32'd1; src_b = 32'd1;
            @(posedge clk); #1;
            chk("stall done_valid", 64'(done_valid), 64'd1);
            chk("stall start_ready", 64'(start_ready), 64'd0);
            chk("stall hi", 64'(hi), 64'(ph));
            chk("stall lo", 64'(lo), 64'(pl));
            $display("stall cycle %0d start_valid=%0d hi=%h lo=%h", c, start_valid, hi, lo);
        end
        op = 2'b10; src_a = 32'd9; src_b = 32'd3; start_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk("handshake done_valid", 64'(done_valid), 64'd0);
        chk("handshake start_ready", 64'(start_ready), 64'd1);
        chk("handshake hi held", 64'(hi), 64'(ph));
        chk("handshake lo held", 64'(lo), 64'(pl));
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("next accept start_ready", 64'(start_ready), 64'd0);
        wait_done(2'b10, lat, badcmd);
        chk("next job latency", 64'(lat), 64'd32);
        chk("next job lo", 64'(lo), 64'd3);
        chk("next job hi", 64'(hi), 64'd0);
        $display("job after stall DIVU 9/3 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;

        // Reset mid-run at count 16 of a divide-by-zero job.
        op = 2'b10; src_a = 32'h12345678; src_b = 32'h0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("midrun alu_command", 64'(alu_command), 64'd1);
        chk("midrun dbz", 64'(div_by_zero), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("post_reset");
        job_and_check("post_reset_div", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
